// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions: default formats, saturation bounds,
// rounding constant and the MAC FSM state type.
package fxp_pkg;

  localparam int FXP_N_DEF = 8;
  localparam int FXP_F_DEF = 7;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } fxp_state_e;

  // Largest representable value of an n-bit signed result: 2^(n-1)-1
  function automatic longint fxp_sat_max(input int n);
    return (64'sd1 <<< (n - 1)) - 64'sd1;
  endfunction

  // Smallest representable value of an n-bit signed result: -2^(n-1)
  function automatic longint fxp_sat_min(input int n);
    return -(64'sd1 <<< (n - 1));
  endfunction

  // Round-half-up constant for dropping f fractional bits: 2^(f-1)
  function automatic longint fxp_round_const(input int f);
    if (f > 0) begin
      return 64'sd1 <<< (f - 1);
    end else begin
      return 64'sd0;
    end
  endfunction

endpackage

// File: rtl/fxp_requant.sv
// Combinational requantizer: round a wide accumulator by dropping F
// fractional bits, then saturate into an N-bit signed result.
module fxp_requant
  import fxp_pkg::*;
#(
  parameter int ACC_W = 19,
  parameter int N     = FXP_N_DEF,
  parameter int F     = FXP_F_DEF
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [N-1:0]     y_o,
  output logic                    sat_o
);

  // One extra bit of headroom so adding the rounding constant cannot wrap
  localparam logic signed [ACC_W:0] RND_C = (ACC_W+1)'(fxp_round_const(F));
  localparam logic signed [ACC_W:0] MAX_C = (ACC_W+1)'(fxp_sat_max(N));
  localparam logic signed [ACC_W:0] MIN_C = (ACC_W+1)'(fxp_sat_min(N));

  logic signed [ACC_W:0] ext_s;
  logic signed [ACC_W:0] q_s;

  assign ext_s = $signed({acc_i[ACC_W-1], acc_i}) + RND_C;
  assign q_s   = ext_s >>> F;

  // Clip the rounded value into the output range and flag any clipping
  always_comb begin
    y_o   = q_s[N-1:0];
    sat_o = 1'b0;
    if (q_s > MAX_C) begin
      y_o   = MAX_C[N-1:0];
      sat_o = 1'b1;
    end else if (q_s < MIN_C) begin
      y_o   = MIN_C[N-1:0];
      sat_o = 1'b1;
    end else begin
      y_o   = q_s[N-1:0];
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/fxp_mac_acc.sv
// Fixed-point dot-product MAC: accumulates LEN full-precision products,
// then presents one rounded, saturated N-bit result with a valid/ready
// handshake. Optional saturation flag output: FXP_MAC_SAT_FLAG_EN.
module fxp_mac_acc
  import fxp_pkg::*;
#(
  parameter int N   = FXP_N_DEF,
  parameter int F   = FXP_F_DEF,
  parameter int LEN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_a,
  input  logic signed [N-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef FXP_MAC_SAT_FLAG_EN
  output logic                out_sat,
`endif
  output logic signed [N-1:0] out_y
);

  // Sized so that LEN worst-case products can never overflow the sum
  localparam int ACC_W = 2 * N + $clog2(LEN) + 1;
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  fxp_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [N-1:0]     y_q, y_d;

  logic signed [2*N-1:0]   prod_s;
  logic signed [ACC_W-1:0] acc_sum_s;
  logic signed [N-1:0]     req_y_s;
  logic                    beat_s;

`ifdef FXP_MAC_SAT_FLAG_EN
  logic sat_q, sat_d;
  logic req_sat_s;
`else
  logic req_sat_unused_s;
`endif

  assign prod_s    = in_a * in_b;
  assign acc_sum_s = acc_q + ACC_W'(prod_s);
  assign beat_s    = in_valid && (state_q == ST_ACCUM);

  // The requantizer sees the sum including the current beat's product
  fxp_requant #(
    .ACC_W (ACC_W),
    .N     (N),
    .F     (F)
  ) u_requant (
    .acc_i (acc_sum_s),
    .y_o   (req_y_s),
`ifdef FXP_MAC_SAT_FLAG_EN
    .sat_o (req_sat_s)
`else
    .sat_o (req_sat_unused_s)
`endif
  );

  // Next-state logic: accumulate in ACCUM, capture result on the last beat,
  // release and clear the accumulator on the result handshake
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
`ifdef FXP_MAC_SAT_FLAG_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      ST_ACCUM: begin
        if (beat_s) begin
          acc_d = acc_sum_s;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_HOLD;
            y_d     = req_y_s;
`ifdef FXP_MAC_SAT_FLAG_EN
            sat_d   = req_sat_s;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          acc_d = acc_q;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          acc_d   = {ACC_W{1'b0}};
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        acc_d   = {ACC_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, accumulator, beat counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= {ACC_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      y_q     <= {N{1'b0}};
`ifdef FXP_MAC_SAT_FLAG_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
`ifdef FXP_MAC_SAT_FLAG_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign out_y     = y_q;
`ifdef FXP_MAC_SAT_FLAG_EN
  assign out_sat   = sat_q;
`endif

endmodule

// File: tb/tb_fxp_mac_acc.sv
// Directed bench for fxp_mac_acc (N=8, F=7, LEN=4) with a result scoreboard.
module tb_fxp_mac_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'd0;
  logic [7:0] in_b = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_y;
`ifdef FXP_MAC_SAT_FLAG_EN
  logic       out_sat;
`endif

  int checks = 0;
  int errors = 0;

  // expected result: {sat, y}
  logic [8:0] sb[$];
  longint     acc_m = 0;
  int         cnt_m = 0;

  fxp_mac_acc #(.N(8), .F(7), .LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FXP_MAC_SAT_FLAG_EN
    .out_sat   (out_sat),
`endif
    .out_y     (out_y)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference requantization of the bench's own accumulator
  function automatic logic [8:0] model(input longint acc);
    longint q;
    q = (acc + 64) >>> 7;
    if (q > 127)       return {1'b1, 8'h7F};
    else if (q < -128) return {1'b1, 8'h80};
    else               return {1'b0, 8'(q)};
  endfunction

  // Offer one beat in ACCUM, then idle for gap cycles
  task automatic beat(input logic signed [7:0] a, input logic signed [7:0] b, input int gap);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_m += longint'(a) * longint'(b);
    cnt_m++;
    if (cnt_m == 4) begin
      sb.push_back(model(acc_m));
      acc_m = 0;
      cnt_m = 0;
      chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    end
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Check the held result, stall for hold cycles offering ignored beats, then handshake
  task automatic collect(input string tag, input int hold);
    logic [8:0] exp;
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
    exp = (sb.size() != 0) ? sb.pop_front() : 9'h000;
    chk({tag, "_y"}, {24'd0, out_y}, {24'd0, exp[7:0]});
`ifdef FXP_MAC_SAT_FLAG_EN
    chk({tag, "_sat"}, {31'd0, out_sat}, {31'd0, exp[8]});
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_a = 8'sd100;
      in_b = 8'sd100;
      @(posedge clk);
      #1;
      chk({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_y"}, {24'd0, out_y}, {24'd0, exp[7:0]});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_post_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_y", {24'd0, out_y}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef FXP_MAC_SAT_FLAG_EN
    chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // positive saturation: acc=16384, q=128 -> 127
    repeat (4) beat(8'sd64, 8'sd64, 0);
    collect("pos_sat", 0);

    // cancellation to zero
    beat(8'sd64, 8'sd64, 0);
    beat(8'sd64, -8'sd64, 0);
    beat(8'sd0, 8'sd0, 0);
    beat(8'sd0, 8'sd0, 0);
    collect("cancel", 0);

    // rounding just below half -> 0
    beat(8'sd1, 8'sd63, 0);
    repeat (3) beat(8'sd0, 8'sd0, 0);
    collect("round_lo", 0);

    // rounding exactly at half -> 1
    beat(8'sd1, 8'sd64, 0);
    repeat (3) beat(8'sd0, 8'sd0, 0);
    collect("round_half", 0);

    // small negative rounds to -1
    beat(-8'sd1, 8'sd65, 0);
    repeat (3) beat(8'sd0, 8'sd0, 0);
    collect("round_neg", 0);

    // negative saturation: q=-508 -> -128
    repeat (4) beat(-8'sd128, 8'sd127, 0);
    collect("neg_sat", 3);

    // vector after the stalled result must not include the ignored beats
    beat(8'sd1, 8'sd64, 0);
    repeat (3) beat(8'sd0, 8'sd0, 0);
    collect("after_stall", 0);

    // gaps between beats give the same result as back-to-back
    beat(8'sd32, 8'sd32, 2);
    beat(8'sd16, -8'sd8, 1);
    beat(-8'sd5, 8'sd7, 3);
    beat(8'sd50, 8'sd3, 0);
    collect("gaps", 0);

    // reset after two beats discards the partial vector
    beat(8'sd64, 8'sd64, 0);
    beat(8'sd64, 8'sd64, 0);
    #2;
    rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    acc_m = 0;
    cnt_m = 0;
    @(posedge clk);
    #1;
    beat(8'sd1, 8'sd64, 0);
    beat(8'sd2, 8'sd64, 0);
    beat(8'sd0, 8'sd0, 0);
    beat(8'sd0, 8'sd0, 0);
    collect("after_rst", 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fxp_mac_acc.md
FXP_MAC_ACC -- requirements
Module: fxp_mac_acc

Interface
REQ-001 SHALL have parameter N, default 8, meaning the operand and result width in signed Q(N-F).F format.
REQ-002 SHALL have parameter F, default 7, meaning the number of fractional bits.
REQ-003 SHALL have parameter LEN, default 16, meaning the products per dot product (LEN >= 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the operand pair.
REQ-008 SHALL have ports in_a and in_b, input, N bits each, signed: the operands.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port out_y, output, N bits, signed: the requantized dot product.
REQ-012 SHALL have port out_sat, output, 1 bit: the result saturated (present only under REQ-027).

Function
REQ-013 SHALL have a two-state FSM: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-014 SHALL treat a beat as accepted when in_valid && in_ready at a rising clk edge.
REQ-015 SHALL add in_a*in_b as a full-precision signed 2N-bit product to acc on each accepted beat, with no per-product rounding.
REQ-016 SHALL size acc to ACC_W = 2N + $clog2(LEN) + 1 bits, so acc never overflows for any operands.
REQ-017 SHALL count accepted beats in cnt (0..LEN-1); the LEN-th accepted beat wraps cnt to 0 and moves the FSM ACCUM->HOLD.
REQ-018 SHALL compute the result on the LEN-th beat and register it: q = (acc_final + 2^(F-1)) >>> F, arithmetic, evaluated at ACC_W+1 bits, where acc_final includes that beat's product.
REQ-019 SHALL saturate q to [-2^(N-1), 2^(N-1)-1] and drive the saturated value on out_y.
REQ-020 SHALL assert out_valid exactly one cycle after the final beat is accepted (latency 1).
REQ-021 SHALL hold out_y and out_sat stable in HOLD until out_valid && out_ready.
REQ-022 SHALL, on the result handshake, clear acc to 0 and return to ACCUM; in_ready rises on the following cycle, so there is no overlap of result and next vector.
REQ-023 SHALL leave acc and cnt unchanged on cycles in ACCUM with in_valid=0.
REQ-024 SHALL ignore in_valid while in HOLD.

Reset
REQ-025 SHALL, while rst_n=0, force: FSM=ACCUM, acc=0, cnt=0, out_y=0, out_valid=0, out_sat=0; in_ready is 1 once reset is released.
REQ-026 SHALL discard any partial vector or pending result on reset mid-operation; the first beat after reset starts a new vector.

Configuration
REQ-027 SHALL, with FXP_MAC_SAT_FLAG_EN defined, include out_sat, registered alongside out_y, which is 1 when q was clipped by REQ-019, else 0; without the macro, SHALL omit the port and its logic, with out_y unchanged.

Structure
REQ-028 SHALL take the default N and F, the saturation bounds and the rounding constant from shared package fxp_pkg, which also holds the FSM state enum typedef.
REQ-029 SHALL implement rounding plus saturation as sub-module fxp_requant (parameters ACC_W, N, F; purely combinational), reusable by other fixed-point stages.

Verification (N=8, F=7, LEN=4)
REQ-030 SHALL cover: four beats (64,64) -> acc=16384, q=128, out_y=127, out_sat=1.
REQ-031 SHALL cover: (64,64),(64,-64),(0,0),(0,0) -> out_y=0, out_sat=0; and (1,63),(0,0)x3 -> 0; and (1,64),(0,0)x3 -> 1.
REQ-032 SHALL cover: (-1,65),(0,0)x3 -> out_y=-1; and four beats (-128,127) -> q=-508, out_y=-128, out_sat=1.
REQ-033 SHALL cover: out_ready held low 3 cycles after out_valid -> out_y stable, in_ready=0, beats offered in that window not accumulated; the next vector is unaffected.
REQ-034 SHALL cover: in_valid gaps between beats -> same result as back-to-back; rst_n pulsed after 2 beats -> the next 4 beats yield a result computed from those 4 only.
